dmem_arbiter: RTL and testbench
===============================

DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 Parameter MEM_SIZE, default 64, data memory depth in 32-bit words.
REQ-002 Parameter MAX_WAIT, default 4, max arbitration losses port 1 suffers before forced grant.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 p0_req / p1_req  input  1  access request, held with stable command until grant seen; port 0 = pipeline MEM stage, port 1 = debug/DMA.
REQ-006 p0_we / p1_we  input  1  1 = write, 0 = read.
REQ-007 p0_addr / p1_addr  input  32  byte address.
REQ-008 p0_wdata / p1_wdata  input  32  write data.
REQ-009 p0_gnt / p1_gnt  output  1  one-cycle pulse: command executing this cycle.
REQ-010 p0_rvalid / p1_rvalid  output  1  one-cycle response pulse, cycle after gnt.
REQ-011 rdata  output  32  read data, valid with rvalid.
REQ-012 err  output  1  error flag, valid with rvalid.
REQ-013 mem_read, mem_write  output  1  memory strobes.
REQ-014 mem_addr, mem_wdata  output  32  memory address and write data.
REQ-015 mem_rdata  input  32  combinational memory read data.

Function
REQ-016 FSM states IDLE, BUSY; IDLE->BUSY on edge with any req high; BUSY->IDLE unconditionally; max one access per 2 cycles.
REQ-017 In IDLE, winner latched into command register (port id, we, addr, wdata) at edge; no request -> stay IDLE, strobes low.
REQ-018 Priority: port 0 wins unless wait_cnt == MAX_WAIT and p1_req high, then port 1 wins.
REQ-019 wait_cnt (width clog2(MAX_WAIT+1)) increments, saturating at MAX_WAIT, on each IDLE edge where p1_req high and port 0 wins; clears when port 1 latched.
REQ-020 In BUSY, gnt of latched port high; mem_addr/mem_wdata driven from command register; mem_write = we & legal; mem_read = ~we & legal.
REQ-021 Legal = addr[1:0] == 0 and addr[31:2] < MEM_SIZE.
REQ-022 Illegal access: both strobes 0, no memory change, rdata 0, err 1 with rvalid.
REQ-023 End of BUSY: rdata registers mem_rdata for legal reads, 0 for writes/illegal; err registered; rvalid of that port high the following cycle only.
REQ-024 Requests during BUSY ignored; requester observing gnt drops or changes command by next edge, so next IDLE cycle re-arbitrates fresh.
REQ-025 Simultaneous req, wait_cnt < MAX_WAIT: port 0 served, port 1 waits with no grant.
REQ-026 Outside BUSY: mem_read, mem_write, gnt low; mem_addr, mem_wdata hold last values.

Reset
REQ-027 On edge with rst high: state IDLE, wait_cnt 0, command register 0, rdata 0, err 0, all rvalid/gnt 0.
REQ-028 mem_write and mem_read SHALL be forced 0 combinationally while rst high, so no write commits on a reset edge, including reset mid-BUSY.
REQ-029 Access interrupted by reset produces no gnt-completion rvalid; requester re-issues.

Structure
REQ-030 State encoding, default MEM_SIZE/MAX_WAIT, port-id constants in shared package/include file used by arbiter and bench.
REQ-031 One sub-module dmem_addr_check (combinational, MEM_SIZE param) computing legal; instantiated once on command register address.

Verification
REQ-032 Single p0 write addr 0x10 data 0xDEADBEEF, then p0 read 0x10 -> gnt next cycle, memory word 4 updated, read rvalid rdata 0xDEADBEEF err 0.
REQ-033 p0_req and p1_req held continuously, MAX_WAIT 4 -> grant order p0,p0,p0,p0,p1 repeating; wait_cnt never exceeds 4.
REQ-034 p1 read addr 0x102 (misaligned) and 0x100 (word 64, out of range) -> mem_read 0 both, rvalid with err 1, rdata 0.
REQ-035 rst asserted during BUSY of p0 write 0x8 data 0x12345678 -> mem_write 0 that edge, word 2 unchanged, all outputs 0 next cycle.
REQ-036 Only p1_req, p1 write 0xFC data 0xA5A5A5A5 -> granted first IDLE cycle, word 63 updated, wait_cnt stays 0.

Source files
------------

// File: rtl/dmem_arbiter_pkg.sv
// Shared constants for the data-memory arbiter: FSM encoding, default sizing, port ids.
// Pure declarations; no logic, so latency and backpressure are not applicable here.
package dmem_arbiter_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_t;

  localparam int   DEF_MEM_SIZE = 64;
  localparam int   DEF_MAX_WAIT = 4;
  localparam logic PORT0        = 1'b0;
  localparam logic PORT1        = 1'b1;

endpackage

// File: rtl/dmem_addr_check.sv
// Word-aligned, in-range address check for the latched command; purely combinational.
// Zero latency, no handshake; the arbiter samples o_legal during its BUSY cycle.
module dmem_addr_check
  import dmem_arbiter_pkg::*;
#(
  parameter int MEM_SIZE = DEF_MEM_SIZE
) (
  input  logic [31:0] i_addr,
  output logic        o_legal
);

  localparam logic [31:0] LP_SIZE = 32'(MEM_SIZE);

  assign o_legal = (i_addr[1:0] == 2'b00) && ({2'b00, i_addr[31:2]} < LP_SIZE);

endmodule

// File: rtl/dmem_arbiter.sv
// Two-port data-memory arbiter: port 0 priority, port 1 forced in after MAX_WAIT losses.
// gnt one cycle after the request is latched, rvalid one cycle after gnt; loser holds its request.
module dmem_arbiter
  import dmem_arbiter_pkg::*;
#(
  parameter int MEM_SIZE = DEF_MEM_SIZE,
  parameter int MAX_WAIT = DEF_MAX_WAIT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        p0_req,
  input  logic        p0_we,
  input  logic [31:0] p0_addr,
  input  logic [31:0] p0_wdata,
  input  logic        p1_req,
  input  logic        p1_we,
  input  logic [31:0] p1_addr,
  input  logic [31:0] p1_wdata,
  output logic        p0_gnt,
  output logic        p1_gnt,
  output logic        p0_rvalid,
  output logic        p1_rvalid,
  output logic [31:0] rdata,
  output logic        err,
  output logic        mem_read,
  output logic        mem_write,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata
);

  localparam int            WW     = (MAX_WAIT < 1) ? 1 : $clog2(MAX_WAIT + 1);
  localparam logic [WW-1:0] LP_MAX = WW'(MAX_WAIT);
  localparam logic [WW-1:0] LP_ONE = WW'(1);

  state_t        r_state;
  state_t        w_state_nxt;
  logic [WW-1:0] r_wait_cnt;
  logic          r_cmd_port;
  logic          r_cmd_we;
  logic [31:0]   r_cmd_addr;
  logic [31:0]   r_cmd_wdata;
  logic [31:0]   r_rdata;
  logic          r_err;
  logic          r_rvalid0;
  logic          r_rvalid1;

  logic          w_legal;
  logic          w_busy;
  logic          w_latch;
  logic          w_sel_p1;

  dmem_addr_check #(
    .MEM_SIZE(MEM_SIZE)
  ) u_addr_check (
    .i_addr (r_cmd_addr),
    .o_legal(w_legal)
  );

  // Port 1 wins when it is alone, or when it has been starved MAX_WAIT times.
  assign w_sel_p1 = p1_req & (~p0_req | (r_wait_cnt == LP_MAX));

  always_comb begin
    w_state_nxt = r_state;
    w_latch     = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (p0_req || p1_req) begin
          w_state_nxt = ST_BUSY;
          w_latch     = 1'b1;
        end
      end
      ST_BUSY: w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Masking with rst keeps a reset edge landing mid-BUSY from committing a write.
  assign w_busy    = (r_state == ST_BUSY) & ~rst;
  assign p0_gnt    = w_busy & (r_cmd_port == PORT0);
  assign p1_gnt    = w_busy & (r_cmd_port == PORT1);
  assign mem_write = w_busy & r_cmd_we & w_legal;
  assign mem_read  = w_busy & ~r_cmd_we & w_legal;
  assign mem_addr  = r_cmd_addr;
  assign mem_wdata = r_cmd_wdata;
  assign rdata     = r_rdata;
  assign err       = r_err;
  assign p0_rvalid = r_rvalid0;
  assign p1_rvalid = r_rvalid1;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_wait_cnt  <= '0;
      r_cmd_port  <= PORT0;
      r_cmd_we    <= 1'b0;
      r_cmd_addr  <= '0;
      r_cmd_wdata <= '0;
      r_rdata     <= '0;
      r_err       <= 1'b0;
      r_rvalid0   <= 1'b0;
      r_rvalid1   <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_rvalid0 <= 1'b0;
      r_rvalid1 <= 1'b0;
      if (w_latch) begin
        r_cmd_port  <= w_sel_p1 ? PORT1 : PORT0;
        r_cmd_we    <= w_sel_p1 ? p1_we : p0_we;
        r_cmd_addr  <= w_sel_p1 ? p1_addr : p0_addr;
        r_cmd_wdata <= w_sel_p1 ? p1_wdata : p0_wdata;
        if (w_sel_p1) begin
          r_wait_cnt <= '0;
        end else if (p1_req && (r_wait_cnt != LP_MAX)) begin
          r_wait_cnt <= r_wait_cnt + LP_ONE;
        end
      end
      if (r_state == ST_BUSY) begin
        r_rdata   <= (w_legal && !r_cmd_we) ? mem_rdata : '0;
        r_err     <= ~w_legal;
        r_rvalid0 <= (r_cmd_port == PORT0);
        r_rvalid1 <= (r_cmd_port == PORT1);
      end
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: directed vector table, starvation and reset corner cases,
// then randomized two-port traffic checked against a transaction-level model.
module tb_dmem_arbiter;
  import dmem_arbiter_pkg::*;

  localparam int MS = DEF_MEM_SIZE;
  localparam int MW = DEF_MAX_WAIT;

  logic        clk;
  logic        rst;
  logic        p0_req, p0_we, p1_req, p1_we;
  logic [31:0] p0_addr, p0_wdata, p1_addr, p1_wdata;
  logic        p0_gnt, p1_gnt, p0_rvalid, p1_rvalid;
  logic [31:0] rdata;
  logic        err;
  logic        mem_read, mem_write;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic        mem_init;

  logic [31:0] mem     [0:MS-1];
  logic [31:0] ref_mem [0:MS-1];

  int errors = 0;
  int checks = 0;

  dmem_arbiter #(.MEM_SIZE(MS), .MAX_WAIT(MW)) dut (
    .clk(clk), .rst(rst),
    .p0_req(p0_req), .p0_we(p0_we), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
    .p1_req(p1_req), .p1_we(p1_we), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
    .p0_gnt(p0_gnt), .p1_gnt(p1_gnt), .p0_rvalid(p0_rvalid), .p1_rvalid(p1_rvalid),
    .rdata(rdata), .err(err), .mem_read(mem_read), .mem_write(mem_write),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign mem_rdata = (mem_addr[31:2] < 30'(MS)) ? mem[mem_addr[7:2]] : 32'hBAD0BAD0;

  always @(posedge clk) begin
    if (mem_init) begin
      for (int i = 0; i < MS; i++) mem[i] <= 32'd0;
    end else if (mem_write) begin
      mem[mem_addr[7:2]] <= mem_wdata;
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic bit ref_legal(input logic [31:0] a);
    return ((a % 32'd4) == 32'd0) && ((a / 32'd4) < 32'(MS));
  endfunction

  task automatic set_port(input logic p, input logic req, input logic we,
                          input logic [31:0] addr, input logic [31:0] wdata);
    if (p == PORT0) begin
      p0_req = req; p0_we = we; p0_addr = addr; p0_wdata = wdata;
    end else begin
      p1_req = req; p1_we = we; p1_addr = addr; p1_wdata = wdata;
    end
  endtask

  // One isolated transaction on one port, starting from an idle cycle.
  task automatic run_txn(input logic p, input logic we, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic exp_err,
                         input logic [31:0] exp_rdata);
    set_port(p, 1'b1, we, addr, wdata);
    tick;
    chk1("txn_gnt0", p0_gnt, p == PORT0);
    chk1("txn_gnt1", p1_gnt, p == PORT1);
    chk1("txn_mem_write", mem_write, we && !exp_err);
    chk1("txn_mem_read", mem_read, !we && !exp_err);
    chk("txn_mem_addr", mem_addr, addr);
    set_port(p, 1'b0, we, addr, wdata);
    tick;
    chk1("txn_rvalid0", p0_rvalid, p == PORT0);
    chk1("txn_rvalid1", p1_rvalid, p == PORT1);
    chk("txn_rdata", rdata, exp_rdata);
    chk1("txn_err", err, exp_err);
    chk1("txn_idle_gnt", p0_gnt | p1_gnt, 1'b0);
    chk("txn_addr_hold", mem_addr, addr);
    tick;
    chk1("txn_rvalid_pulse", p0_rvalid | p1_rvalid, 1'b0);
    if (we && !exp_err) ref_mem[addr / 4] = wdata;
  endtask

  typedef struct {
    logic        port;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        exp_err;
    logic [31:0] exp_rdata;
  } vec_t;

  vec_t vt [11];

  logic        pend   [2];
  logic        pwe    [2];
  logic [31:0] paddr  [2];
  logic [31:0] pwdata [2];

  initial begin
    int          m_cnt;
    logic        w;
    logic        prev_valid, prev_port, prev_err, lg;
    logic [31:0] prev_rdata;
    int          bad;

    vt[0]  = '{PORT0, 1'b1, 32'h10,  32'hDEADBEEF, 1'b0, 32'h0};
    vt[1]  = '{PORT0, 1'b0, 32'h10,  32'h0,        1'b0, 32'hDEADBEEF};
    vt[2]  = '{PORT1, 1'b0, 32'h102, 32'h0,        1'b1, 32'h0};
    vt[3]  = '{PORT1, 1'b0, 32'h100, 32'h0,        1'b1, 32'h0};
    vt[4]  = '{PORT1, 1'b1, 32'hFC,  32'hA5A5A5A5, 1'b0, 32'h0};
    vt[5]  = '{PORT0, 1'b0, 32'hFC,  32'h0,        1'b0, 32'hA5A5A5A5};
    vt[6]  = '{PORT1, 1'b0, 32'h10,  32'h0,        1'b0, 32'hDEADBEEF};
    vt[7]  = '{PORT0, 1'b1, 32'h3,   32'h11111111, 1'b1, 32'h0};
    vt[8]  = '{PORT0, 1'b0, 32'h0,   32'h0,        1'b0, 32'h0};
    vt[9]  = '{PORT1, 1'b1, 32'h100, 32'h77777777, 1'b1, 32'h0};
    vt[10] = '{PORT1, 1'b1, 32'h8,   32'hCAFEF00D, 1'b0, 32'h0};

    for (int i = 0; i < MS; i++) ref_mem[i] = 32'd0;
    p0_req = 0; p0_we = 0; p0_addr = 0; p0_wdata = 0;
    p1_req = 0; p1_we = 0; p1_addr = 0; p1_wdata = 0;
    rst = 1'b1; mem_init = 1'b1;
    tick; tick;
    chk1("rst_gnt", p0_gnt | p1_gnt, 1'b0);
    chk1("rst_rvalid", p0_rvalid | p1_rvalid, 1'b0);
    chk1("rst_strobes", mem_read | mem_write, 1'b0);
    chk("rst_rdata", rdata, 32'h0);
    chk1("rst_err", err, 1'b0);
    chk("rst_mem_addr", mem_addr, 32'h0);
    rst = 1'b0; mem_init = 1'b0;
    tick;
    chk1("idle_no_req_strobes", mem_read | mem_write | p0_gnt | p1_gnt, 1'b0);

    for (int i = 0; i < 11; i++)
      run_txn(vt[i].port, vt[i].we, vt[i].addr, vt[i].wdata, vt[i].exp_err, vt[i].exp_rdata);
    chk("mem_word4", mem[4], 32'hDEADBEEF);
    chk("mem_word63", mem[63], 32'hA5A5A5A5);
    chk("mem_word0", mem[0], 32'h0);
    chk("mem_word2", mem[2], 32'hCAFEF00D);

    // Both ports held: port 1 must get in exactly every fifth grant.
    set_port(PORT0, 1'b1, 1'b0, 32'h10, 32'h0);
    set_port(PORT1, 1'b1, 1'b0, 32'hFC, 32'h0);
    for (int g = 0; g < 10; g++) begin
      tick;
      chk1("starve_gnt1", p1_gnt, (g % 5) == 4);
      chk1("starve_gnt0", p0_gnt, (g % 5) != 4);
      chk1("starve_cnt_bound", dut.r_wait_cnt <= 3'(MW), 1'b1);
      tick;
      chk("starve_rdata", rdata, ((g % 5) == 4) ? 32'hA5A5A5A5 : 32'hDEADBEEF);
    end
    set_port(PORT0, 1'b0, 1'b0, 32'h10, 32'h0);
    set_port(PORT1, 1'b0, 1'b0, 32'hFC, 32'h0);
    tick;

    // Reset landing in the BUSY cycle of a write.
    set_port(PORT0, 1'b1, 1'b1, 32'h8, 32'h12345678);
    tick;
    chk1("rstbusy_gnt_before", p0_gnt, 1'b1);
    rst = 1'b1;
    #1;
    chk1("rstbusy_mem_write", mem_write, 1'b0);
    chk1("rstbusy_mem_read", mem_read, 1'b0);
    tick;
    rst = 1'b0;
    set_port(PORT0, 1'b0, 1'b0, 32'h0, 32'h0);
    #1;
    chk1("rstbusy_gnt_after", p0_gnt | p1_gnt, 1'b0);
    chk1("rstbusy_rvalid", p0_rvalid | p1_rvalid, 1'b0);
    chk("rstbusy_rdata", rdata, 32'h0);
    chk1("rstbusy_err", err, 1'b0);
    chk("rstbusy_mem_addr", mem_addr, 32'h0);
    chk("rstbusy_mem_wdata", mem_wdata, 32'h0);
    chk("rstbusy_word2", mem[2], 32'hCAFEF00D);
    tick;
    chk1("rstbusy_no_completion", p0_rvalid | p1_rvalid, 1'b0);

    // Randomized traffic against the transaction-level model.
    m_cnt = 0;
    prev_valid = 1'b0; prev_port = 1'b0; prev_err = 1'b0; prev_rdata = 32'h0;
    for (int p = 0; p < 2; p++) begin
      pend[p] = 1'b0; pwe[p] = 1'b0; paddr[p] = 32'h0; pwdata[p] = 32'h0;
    end
    for (int r = 0; r < 500; r++) begin
      for (int p = 0; p < 2; p++) begin
        if (!pend[p] && ($urandom_range(0, 99) < 60)) begin
          int k;
          k = $urandom_range(0, 9);
          pend[p]   = 1'b1;
          pwe[p]    = $urandom_range(0, 1) == 1;
          pwdata[p] = $urandom;
          if (k < 7)       paddr[p] = 32'($urandom_range(0, MS - 1)) * 4;
          else if (k == 7) paddr[p] = 32'($urandom_range(0, MS - 1)) * 4 + 32'($urandom_range(1, 3));
          else if (k == 8) paddr[p] = 32'(MS + $urandom_range(0, 200)) * 4;
          else             paddr[p] = $urandom;
        end
      end
      set_port(PORT0, pend[0], pwe[0], paddr[0], pwdata[0]);
      set_port(PORT1, pend[1], pwe[1], paddr[1], pwdata[1]);
      chk1("rnd_rvalid0", p0_rvalid, prev_valid && (prev_port == PORT0));
      chk1("rnd_rvalid1", p1_rvalid, prev_valid && (prev_port == PORT1));
      if (prev_valid) begin
        chk("rnd_rdata", rdata, prev_rdata);
        chk1("rnd_err", err, prev_err);
      end
      chk1("rnd_idle_quiet", p0_gnt | p1_gnt | mem_read | mem_write, 1'b0);
      if (!pend[0] && !pend[1]) begin
        prev_valid = 1'b0;
        tick;
        continue;
      end
      w = pend[1] && (!pend[0] || (m_cnt == MW));
      if (w) m_cnt = 0;
      else if (pend[1] && (m_cnt < MW)) m_cnt = m_cnt + 1;
      tick;
      lg = ref_legal(paddr[w]);
      chk1("rnd_gnt0", p0_gnt, w == PORT0);
      chk1("rnd_gnt1", p1_gnt, w == PORT1);
      chk1("rnd_mem_write", mem_write, lg && pwe[w]);
      chk1("rnd_mem_read", mem_read, lg && !pwe[w]);
      chk("rnd_mem_addr", mem_addr, paddr[w]);
      if (lg && pwe[w]) chk("rnd_mem_wdata", mem_wdata, pwdata[w]);
      prev_rdata = (lg && !pwe[w]) ? ref_mem[paddr[w] / 4] : 32'h0;
      prev_err   = !lg;
      if (lg && pwe[w]) ref_mem[paddr[w] / 4] = pwdata[w];
      pend[w] = 1'b0;
      set_port(w, 1'b0, pwe[w], paddr[w], pwdata[w]);
      tick;
      prev_valid = 1'b1;
      prev_port  = w;
    end
    set_port(PORT0, 1'b0, 1'b0, 32'h0, 32'h0);
    set_port(PORT1, 1'b0, 1'b0, 32'h0, 32'h0);
    tick; tick;
    bad = 0;
    for (int i = 0; i < MS; i++) if (mem[i] !== ref_mem[i]) bad++;
    chk("rnd_final_mem_mismatch_words", 32'(bad), 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
